seg_display_mux: RTL and testbench
==================================

SEG_DISPLAY_MUX -- requirements
Module: seg_display_mux

Interface
REQ-001 Parameter: SEG_ACTIVE_LOW, 1, polarity of seg and an; 1 = active-low, 0 = active-high.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 scan_tick  input  1  single-cycle enable; advances the digit scan.
REQ-005 blink_tick  input  1  single-cycle enable; toggles the blink phase.
REQ-006 minutes  input  6  binary minutes from the counter, 0-59 valid.
REQ-007 seconds  input  6  binary seconds from the counter, 0-59 valid.
REQ-008 adj  input  1  adjust mode active.
REQ-009 sel  input  1  adjust field select; 1 = seconds, 0 = minutes.
REQ-010 paused  input  1  stopwatch paused.
REQ-011 an  output  4  digit enables, registered; an[0] is the rightmost digit.
REQ-012 seg  output  7  segment drives, registered; seg[0]=a ... seg[6]=g.

Function
REQ-013 The block SHALL hold a 2-bit digit_idx, incremented modulo 4 on each cycle with scan_tick=1.
REQ-014 Digit mapping SHALL be fixed:
- idx 0 = seconds ones
- idx 1 = seconds tens
- idx 2 = minutes ones
- idx 3 = minutes tens
REQ-015 The block SHALL snapshot minutes and seconds into internal registers on the cycle where scan_tick=1 and digit_idx=3, so one full scan shows one coherent value.
REQ-016 Snapshot values SHALL be split into tens (value/10) and ones (value%10); leading zeros SHALL be displayed.
REQ-017 A snapshot value of 60-63 SHALL display both digits of that field as a dash (segment g only).
REQ-018 Encoding (active-high, g..a): 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111.
REQ-019 When SEG_ACTIVE_LOW=1, seg and an SHALL be the bitwise inverse of the active-high values.
REQ-020 blink_phase SHALL toggle on each cycle with blink_tick=1.
REQ-021 Blanking SHALL be decided by priority:
- adj=1: digits of the field chosen by sel are blanked while blink_phase=1; the other field is always shown.
- adj=0 and paused=1: all digits are blanked while blink_phase=1.
- otherwise: no digit is blanked.
REQ-022 A blanked digit SHALL keep its an bit asserted and drive all segments off.
REQ-023 On a scan_tick cycle, an and seg SHALL show the new digit_idx from the next cycle on (1-cycle latency).
- Exactly one an bit SHALL be asserted at any time after the first scan_tick.
REQ-024 Between scan_ticks, an and seg SHALL still respond to adj, sel, paused and blink_phase with 1-cycle latency; digit_idx SHALL hold.
REQ-025 When scan_tick and blink_tick occur in the same cycle, both updates SHALL apply, and the registered seg SHALL use the new digit and the new phase.
REQ-026 minutes and seconds changes between snapshots SHALL NOT affect the outputs.

Reset
REQ-027 While reset=1 on a clock edge:
- digit_idx=0, blink_phase=0, snapshot registers=0.
- All an bits deasserted (4'b1111 for SEG_ACTIVE_LOW=1).
- All segments off (7'b1111111 for SEG_ACTIVE_LOW=1).
REQ-028 Reset SHALL take priority over scan_tick and blink_tick in the same cycle.
REQ-029 The first scan_tick after reset SHALL select digit 1 (an=4'b1101, active-low).

Verification
REQ-030 Basic scan: reset; minutes=12, seconds=34; 4 scan_ticks to take the snapshot; 4 more -> seg patterns for 3,2,1,4 at idx 1,2,3,0, with an 1101, 1011, 0111, 1110 (active-low).
REQ-031 Coherency: change seconds from 34 to 35 while idx=1 -> display shows 34 until the cycle after the next idx-3 scan_tick, then 35.
REQ-032 Adjust blink: adj=1, sel=1, blink_phase=1 -> idx 0/1 give seg=1111111 with an still asserted, while idx 2/3 show the minutes; sel=0 -> the minutes digits blank instead.
REQ-033 Pause blink: adj=0, paused=1 -> all digits blank when blink_phase=1 and all shown when blink_phase=0; setting adj=1 overrides pause blanking.
REQ-034 Out-of-range: seconds=61 -> idx 0 and 1 show seg=0111111 (active-low dash).
REQ-035 Mid-scan reset: reset asserted at idx=2 with scan_tick and blink_tick both high -> next cycle an=1111, seg=1111111, idx=0, phase=0.

Source files
------------

// File: rtl/seg_display_mux.sv
// Four-digit MM:SS multiplexer for a seven-segment display: scans one digit per
// scan_tick, shows a per-scan coherent snapshot, and blinks fields for adjust/pause.
module seg_display_mux #(
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scan_tick,
    input  logic       blink_tick,
    input  logic [5:0] minutes,
    input  logic [5:0] seconds,
    input  logic       adj,
    input  logic       sel,
    input  logic       paused,
    output logic [3:0] an,
    output logic [6:0] seg
);

    localparam logic [6:0] SEG_DASH = 7'b1000000;

    logic [1:0] digitIdxReg, digitIdxNext;
    logic       blinkPhaseReg, blinkPhaseNext;
    logic       startedReg, startedNext;
    logic [5:0] snapMinReg, snapMinNext;
    logic [5:0] snapSecReg, snapSecNext;

    logic [3:0] minTens, minOnes, secTens, secOnes;
    logic       minDash, secDash;
    logic [3:0] digitVal;
    logic       isMinutes, isDash, isBlank;
    logic [3:0] anActive;
    logic [6:0] segActive;

    function automatic logic [6:0] encodeDigit(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    // Next-state values: the registered outputs are built from these, so a
    // scan/blink tick is visible on an/seg exactly one cycle later.
    always_comb begin
        digitIdxNext   = digitIdxReg;
        blinkPhaseNext = blinkPhaseReg;
        startedNext    = startedReg;
        snapMinNext    = snapMinReg;
        snapSecNext    = snapSecReg;
        if (scan_tick) begin
            digitIdxNext = digitIdxReg + 2'd1;
            startedNext  = 1'b1;
            if (digitIdxReg == 2'd3) begin
                snapMinNext = minutes;
                snapSecNext = seconds;
            end
        end
        if (blink_tick) begin
            blinkPhaseNext = ~blinkPhaseReg;
        end
    end

    assign minTens = 4'(snapMinNext / 6'd10);
    assign minOnes = 4'(snapMinNext % 6'd10);
    assign secTens = 4'(snapSecNext / 6'd10);
    assign secOnes = 4'(snapSecNext % 6'd10);
    assign minDash = (snapMinNext >= 6'd60);
    assign secDash = (snapSecNext >= 6'd60);

    // Digits 2/3 belong to the minutes field, 0/1 to seconds.
    assign isMinutes = digitIdxNext[1];
    assign isDash    = isMinutes ? minDash : secDash;

    always_comb begin
        digitVal = secOnes;
        case (digitIdxNext)
            2'd0: digitVal = secOnes;
            2'd1: digitVal = secTens;
            2'd2: digitVal = minOnes;
            2'd3: digitVal = minTens;
            default: digitVal = secOnes;
        endcase
    end

    always_comb begin
        isBlank = 1'b0;
        if (adj) begin
            isBlank = blinkPhaseNext && (sel ? !isMinutes : isMinutes);
        end else if (paused) begin
            isBlank = blinkPhaseNext;
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_an
            assign anActive[gi] = startedNext && (digitIdxNext == 2'(gi));
        end
    endgenerate

    always_comb begin
        segActive = 7'b0000000;
        if (startedNext && !isBlank) begin
            segActive = isDash ? SEG_DASH : encodeDigit(digitVal);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            digitIdxReg   <= 2'd0;
            blinkPhaseReg <= 1'b0;
            startedReg    <= 1'b0;
            snapMinReg    <= 6'd0;
            snapSecReg    <= 6'd0;
            an            <= SEG_ACTIVE_LOW ? 4'b1111 : 4'b0000;
            seg           <= SEG_ACTIVE_LOW ? 7'b1111111 : 7'b0000000;
        end else begin
            digitIdxReg   <= digitIdxNext;
            blinkPhaseReg <= blinkPhaseNext;
            startedReg    <= startedNext;
            snapMinReg    <= snapMinNext;
            snapSecReg    <= snapSecNext;
            an            <= SEG_ACTIVE_LOW ? ~anActive : anActive;
            seg           <= SEG_ACTIVE_LOW ? ~segActive : segActive;
        end
    end

endmodule

// File: tb/tb_seg_display_mux.sv
// Directed bench for seg_display_mux (active-low build): scan order, snapshot
// coherency, adjust/pause blanking, dash display and reset priority.
module tb_seg_display_mux;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scan_tick = 1'b0;
    logic       blink_tick = 1'b0;
    logic [5:0] minutes = 6'd0;
    logic [5:0] seconds = 6'd0;
    logic       adj = 1'b0;
    logic       sel = 1'b0;
    logic       paused = 1'b0;
    logic [3:0] an;
    logic [6:0] seg;

    int assertCount = 0;
    int failCount = 0;

    // Active-low segment patterns (inverse of the g..a table)
    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] SOFF = 7'b1111111;
    localparam logic [6:0] SDASH = 7'b0111111;

    seg_display_mux #(.SEG_ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .reset(reset), .scan_tick(scan_tick), .blink_tick(blink_tick),
        .minutes(minutes), .seconds(seconds), .adj(adj), .sel(sel),
        .paused(paused), .an(an), .seg(seg)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic scan_pulse();
        scan_tick = 1'b1;
        step();
        scan_tick = 1'b0;
    endtask

    task automatic blink_pulse();
        blink_tick = 1'b1;
        step();
        blink_tick = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; scan_tick = 1'b1; blink_tick = 1'b1;
        step();
        step();
        scan_tick = 1'b0; blink_tick = 1'b0;
        assertCount++;
        if (an !== 4'b1111 || seg !== SOFF) begin
            failCount++;
            $display("FAIL reset_outputs: an=%b seg=%b, required an=1111 seg=1111111", an, seg);
        end else $display("reset_outputs: an=%b seg=%b ok", an, seg);
        reset = 1'b0;
        step();
        assertCount++;
        if (an !== 4'b1111 || seg !== SOFF) begin
            failCount++;
            $display("FAIL idle_before_scan: an=%b seg=%b, required an=1111 seg=1111111", an, seg);
        end else $display("idle_before_scan: an=%b seg=%b ok", an, seg);
    endtask

    task automatic test_basic_scan();
        logic [3:0] expAn [4];
        logic [6:0] expSeg [4];
        minutes = 6'd12; seconds = 6'd34;
        scan_pulse();
        assertCount++;
        if (an !== 4'b1101 || seg !== S0) begin
            failCount++;
            $display("FAIL first_scan: an=%b seg=%b, required an=1101 seg=%b", an, seg, S0);
        end else $display("first_scan: an=%b seg=%b ok", an, seg);
        for (int i = 0; i < 3; i++) scan_pulse();
        expAn = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
        expSeg = '{S3, S2, S1, S4};
        for (int i = 0; i < 4; i++) begin
            scan_pulse();
            assertCount++;
            if (an !== expAn[i] || seg !== expSeg[i]) begin
                failCount++;
                $display("FAIL basic_scan[%0d]: an=%b seg=%b, required an=%b seg=%b",
                         i, an, seg, expAn[i], expSeg[i]);
            end else $display("basic_scan[%0d]: an=%b seg=%b ok", i, an, seg);
        end
    endtask

    task automatic test_coherency();
        logic [3:0] expAn [7];
        logic [6:0] expSeg [7];
        // idx1 after first pulse; inputs change mid-scan, old snapshot must remain
        expAn = '{4'b1101, 4'b1011, 4'b0111, 4'b1110, 4'b1101, 4'b1011, 4'b0111};
        expSeg = '{S3, S2, S1, S5, S3, S6, S5};
        for (int i = 0; i < 7; i++) begin
            scan_pulse();
            if (i == 0) begin
                seconds = 6'd35;
                minutes = 6'd56;
            end
            assertCount++;
            if (an !== expAn[i] || seg !== expSeg[i]) begin
                failCount++;
                $display("FAIL coherency[%0d]: an=%b seg=%b, required an=%b seg=%b",
                         i, an, seg, expAn[i], expSeg[i]);
            end else $display("coherency[%0d]: an=%b seg=%b ok", i, an, seg);
        end
        minutes = 6'd12; seconds = 6'd34;
        scan_pulse();
        assertCount++;
        if (an !== 4'b1110 || seg !== S4) begin
            failCount++;
            $display("FAIL coherency_restore: an=%b seg=%b, required an=1110 seg=%b", an, seg, S4);
        end else $display("coherency_restore: an=%b seg=%b ok", an, seg);
    endtask

    task automatic test_adjust_blink();
        adj = 1'b1; sel = 1'b1;
        blink_pulse();
        assertCount++;
        if (an !== 4'b1110 || seg !== SOFF) begin
            failCount++;
            $display("FAIL adj_sec_idx0: an=%b seg=%b, required an=1110 seg=1111111", an, seg);
        end else $display("adj_sec_idx0: an=%b seg=%b ok", an, seg);
        scan_pulse();
        assertCount++;
        if (an !== 4'b1101 || seg !== SOFF) begin
            failCount++;
            $display("FAIL adj_sec_idx1: an=%b seg=%b, required an=1101 seg=1111111", an, seg);
        end else $display("adj_sec_idx1: an=%b seg=%b ok", an, seg);
        scan_pulse();
        assertCount++;
        if (an !== 4'b1011 || seg !== S2) begin
            failCount++;
            $display("FAIL adj_sec_idx2: an=%b seg=%b, required an=1011 seg=%b", an, seg, S2);
        end else $display("adj_sec_idx2: an=%b seg=%b ok", an, seg);
        sel = 1'b0;
        step();
        assertCount++;
        if (an !== 4'b1011 || seg !== SOFF) begin
            failCount++;
            $display("FAIL adj_min_idx2: an=%b seg=%b, required an=1011 seg=1111111", an, seg);
        end else $display("adj_min_idx2: an=%b seg=%b ok", an, seg);
        scan_pulse();
        assertCount++;
        if (an !== 4'b0111 || seg !== SOFF) begin
            failCount++;
            $display("FAIL adj_min_idx3: an=%b seg=%b, required an=0111 seg=1111111", an, seg);
        end else $display("adj_min_idx3: an=%b seg=%b ok", an, seg);
        scan_pulse();
        assertCount++;
        if (an !== 4'b1110 || seg !== S4) begin
            failCount++;
            $display("FAIL adj_min_idx0: an=%b seg=%b, required an=1110 seg=%b", an, seg, S4);
        end else $display("adj_min_idx0: an=%b seg=%b ok", an, seg);
        adj = 1'b0;
    endtask

    task automatic test_pause_blink();
        paused = 1'b1;
        step();
        assertCount++;
        if (an !== 4'b1110 || seg !== SOFF) begin
            failCount++;
            $display("FAIL pause_blank: an=%b seg=%b, required an=1110 seg=1111111", an, seg);
        end else $display("pause_blank: an=%b seg=%b ok", an, seg);
        adj = 1'b1; sel = 1'b0;
        step();
        assertCount++;
        if (an !== 4'b1110 || seg !== S4) begin
            failCount++;
            $display("FAIL pause_adj_override: an=%b seg=%b, required an=1110 seg=%b", an, seg, S4);
        end else $display("pause_adj_override: an=%b seg=%b ok", an, seg);
        adj = 1'b0;
        blink_pulse();
        assertCount++;
        if (an !== 4'b1110 || seg !== S4) begin
            failCount++;
            $display("FAIL pause_phase0: an=%b seg=%b, required an=1110 seg=%b", an, seg, S4);
        end else $display("pause_phase0: an=%b seg=%b ok", an, seg);
    endtask

    task automatic test_back_to_back();
        scan_tick = 1'b1; blink_tick = 1'b1;
        step();
        assertCount++;
        if (an !== 4'b1101 || seg !== SOFF) begin
            failCount++;
            $display("FAIL both_ticks_blank: an=%b seg=%b, required an=1101 seg=1111111", an, seg);
        end else $display("both_ticks_blank: an=%b seg=%b ok", an, seg);
        step();
        scan_tick = 1'b0; blink_tick = 1'b0;
        assertCount++;
        if (an !== 4'b1011 || seg !== S2) begin
            failCount++;
            $display("FAIL both_ticks_show: an=%b seg=%b, required an=1011 seg=%b", an, seg, S2);
        end else $display("both_ticks_show: an=%b seg=%b ok", an, seg);
        paused = 1'b0;
    endtask

    task automatic test_out_of_range();
        seconds = 6'd61;
        scan_pulse();
        scan_pulse();
        assertCount++;
        if (an !== 4'b1110 || seg !== SDASH) begin
            failCount++;
            $display("FAIL dash_idx0: an=%b seg=%b, required an=1110 seg=%b", an, seg, SDASH);
        end else $display("dash_idx0: an=%b seg=%b ok", an, seg);
        scan_pulse();
        assertCount++;
        if (an !== 4'b1101 || seg !== SDASH) begin
            failCount++;
            $display("FAIL dash_idx1: an=%b seg=%b, required an=1101 seg=%b", an, seg, SDASH);
        end else $display("dash_idx1: an=%b seg=%b ok", an, seg);
        scan_pulse();
        assertCount++;
        if (an !== 4'b1011 || seg !== S2) begin
            failCount++;
            $display("FAIL dash_min_ok: an=%b seg=%b, required an=1011 seg=%b", an, seg, S2);
        end else $display("dash_min_ok: an=%b seg=%b ok", an, seg);
    endtask

    task automatic test_mid_reset();
        blink_pulse();
        reset = 1'b1; scan_tick = 1'b1; blink_tick = 1'b1;
        step();
        reset = 1'b0; scan_tick = 1'b0; blink_tick = 1'b0;
        assertCount++;
        if (an !== 4'b1111 || seg !== SOFF) begin
            failCount++;
            $display("FAIL mid_reset: an=%b seg=%b, required an=1111 seg=1111111", an, seg);
        end else $display("mid_reset: an=%b seg=%b ok", an, seg);
        // idx=0, phase=0 and cleared snapshot: next scan shows digit 1 as '0', unblanked
        paused = 1'b1; seconds = 6'd34;
        scan_pulse();
        assertCount++;
        if (an !== 4'b1101 || seg !== S0) begin
            failCount++;
            $display("FAIL post_reset_scan: an=%b seg=%b, required an=1101 seg=%b", an, seg, S0);
        end else $display("post_reset_scan: an=%b seg=%b ok", an, seg);
        paused = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_coherency();
        test_adjust_blink();
        test_pause_blink();
        test_back_to_back();
        test_out_of_range();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
